execute_cc_stage: RTL and testbench
===================================

// Module: execute_cc_stage
// PURPOSE
//  Y86-64 execute stage: selects ALU operands, computes valE (add/sub/and/xor), owns the
//  condition-code register (ZF,SF,OF) and evaluates Cnd for jXX/cmovXX.
//  Sits between decode (valA/valB from the register file) and the memory stage.
//  Result is held in a one-entry output register with a valid/ready handshake.
// PARAMETERS
//  WIDTH  64  datapath width; the -8/+8 stack constants are sign-extended to WIDTH
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      upstream has an instruction
//  in_ready   out  1      stage accepts this cycle
//  icode      in   4      Y86 icode
//  ifun       in   4      Y86 ifun
//  valA       in   WIDTH  decoded rA value
//  valB       in   WIDTH  decoded rB value
//  valC       in   WIDTH  immediate/displacement
//  out_valid  out  1      output register holds a result
//  out_ready  in   1      downstream consumes this cycle
//  out_icode  out  4      registered icode
//  out_valE   out  WIDTH  registered ALU result
//  out_valA   out  WIDTH  registered valA pass-through
//  out_cnd    out  1      registered condition result
//  out_stat   out  2      0=AOK, 1=HLT, 2=INS
//  cc         out  3      {ZF,SF,OF}, current CC register
// BEHAVIOUR
//  Reset: out_valid=0; out_icode/valE/valA/cnd/stat=0; cc=3'b100 (ZF=1); halted=0.
//  in_ready = !halted && (!out_valid || out_ready). Accept = in_valid && in_ready.
//  On accept, the output register loads in the same edge; latency is 1 cycle.
//  Output fields hold stable while out_valid && !out_ready.
//  On out_ready with no new accept, out_valid clears.
//  aluA:
//  - valA for icode 2 and 6.
//  - valC for icode 3, 4, 5.
//  - -8 for icode 8 and A.
//  - +8 for icode 9 and B.
//  - 0 otherwise.
//  aluB:
//  - valB for icode 4, 5, 6, 8, 9, A, B.
//  - 0 otherwise.
//  Operation: for icode 6, ifun 0=add, 1=sub (aluB-aluA), 2=and, 3=xor. All other icodes add.
//  Arithmetic is modulo 2^WIDTH.
//  CC updates only on an accepted OPq with valid ifun:
//  - ZF = (valE==0); SF = valE[WIDTH-1].
//  - Add: OF = (aA[msb]==aB[msb]) && (valE[msb]!=aA[msb]).
//  - Sub: OF = (aA[msb]!=aB[msb]) && (valE[msb]!=aB[msb]).
//  - And/xor: OF = 0.
//  Cnd uses the CC value before the current edge's update, so back-to-back OPq then jXX uses the
//  updated CC.
//  Cnd for icode 2/7, by ifun:
//  - 0 = 1.
//  - 1 = (SF^OF)|ZF.
//  - 2 = SF^OF.
//  - 3 = ZF.
//  - 4 = !ZF.
//  - 5 = !(SF^OF).
//  - 6 = !(SF^OF)&&!ZF.
//  - Cnd = 0 for all other icodes.
//  out_stat:
//  - HLT for icode 0.
//  - INS for icode > B, icode 6 with ifun > 3, or icode 2/7 with ifun > 6.
//  - AOK otherwise.
//  An INS instruction never updates CC.
//  Accepting HLT or INS sets halted; in_ready stays 0 until rst. The faulting entry still drains
//  normally.
//  rst mid-stall: rst wins, the pending output is discarded, and CC returns to 3'b100.
// CONFIGURATION
//  EXEC_STALL_CNT_EN defined:
//  - Adds output stall_cnt [31:0], which counts cycles with out_valid && !out_ready.
//  - Saturates at 32'hFFFFFFFF; cleared by rst.
//  EXEC_STALL_CNT_EN undefined: the port and counter are absent; all other behaviour is identical.
// TESTING
//  - OPq xor (6/3), valA=1, valB=2, out_ready=1 -> next cycle out_valE=3, cc=3'b000, out_stat=0.
//  - OPq sub (6/1), valA=5, valB=5, then jXX je (7/3) -> sub: valE=0, cc=3'b100; je: out_cnd=1.
//  - OPq add, valA=valB=64'h7FFF_FFFF_FFFF_FFFF -> valE=64'hFFFF_FFFF_FFFF_FFFE, cc=3'b011;
//    then jl (7/2) -> cnd=0.
//  - pushq (A), valB=64'h100 -> valE=64'hF8, cc unchanged; popq (B), valB=64'h100 -> valE=64'h108.
//  - Hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and outputs stable; stall_cnt=3
//    when EXEC_STALL_CNT_EN is defined.
//  - icode 0 accepted -> out_stat=1, in_ready stays 0. Then icode C -> not accepted.
//    Assert rst -> out_valid=0, cc=3'b100, in_ready=1.

Source files
------------

// File: rtl/execute_cc_stage.sv
`default_nettype none
// ============================================================================
// Module      : execute_cc_stage
// Description : Y86-64 execute stage with ALU, condition-code register, Cnd
//               evaluation and a one-entry valid/ready output register.
//               Optional macro EXEC_STALL_CNT_EN adds a saturating
//               output-stall cycle counter (stall_cnt).
// Revision    : 1.0 - initial release
// ============================================================================
module execute_cc_stage #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       icode,
    input  logic [3:0]       ifun,
    input  logic [WIDTH-1:0] valA,
    input  logic [WIDTH-1:0] valB,
    input  logic [WIDTH-1:0] valC,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_icode,
    output logic [WIDTH-1:0] out_valE,
    output logic [WIDTH-1:0] out_valA,
    output logic             out_cnd,
    output logic [1:0]       out_stat,
    output logic [2:0]       cc
`ifdef EXEC_STALL_CNT_EN
    ,
    output logic [31:0]      stall_cnt
`endif
);

    localparam logic [3:0] c_i_halt  = 4'h0;
    localparam logic [3:0] c_i_rrmov = 4'h2;
    localparam logic [3:0] c_i_irmov = 4'h3;
    localparam logic [3:0] c_i_rmmov = 4'h4;
    localparam logic [3:0] c_i_mrmov = 4'h5;
    localparam logic [3:0] c_i_opq   = 4'h6;
    localparam logic [3:0] c_i_jxx   = 4'h7;
    localparam logic [3:0] c_i_call  = 4'h8;
    localparam logic [3:0] c_i_ret   = 4'h9;
    localparam logic [3:0] c_i_push  = 4'hA;
    localparam logic [3:0] c_i_pop   = 4'hB;

    localparam logic [1:0] c_stat_aok = 2'd0;
    localparam logic [1:0] c_stat_hlt = 2'd1;
    localparam logic [1:0] c_stat_ins = 2'd2;

    localparam logic [2:0] c_cc_reset = 3'b100;

    localparam logic [WIDTH-1:0] c_neg8 = {{(WIDTH-4){1'b1}}, 4'b1000};
    localparam logic [WIDTH-1:0] c_pos8 = WIDTH'(8);

    logic             r_halted;
    logic             r_out_valid;
    logic [3:0]       r_out_icode;
    logic [WIDTH-1:0] r_out_valE;
    logic [WIDTH-1:0] r_out_valA;
    logic             r_out_cnd;
    logic [1:0]       r_out_stat;
    logic [2:0]       r_cc;

    logic             w_in_ready;
    logic             w_accept;
    logic [WIDTH-1:0] w_alu_a;
    logic [WIDTH-1:0] w_alu_b;
    logic [WIDTH-1:0] w_val_e;
    logic             w_of;
    logic [1:0]       w_stat;
    logic             w_cnd;
    logic             w_cc_update;
    logic             w_zf;
    logic             w_sf;
    logic             w_lt;

    assign w_in_ready = !r_halted && (!r_out_valid || out_ready);
    assign w_accept   = in_valid && w_in_ready;

    always_comb begin
        w_alu_a = '0;
        w_alu_b = '0;
        case (icode)
            c_i_rrmov, c_i_opq:             w_alu_a = valA;
            c_i_irmov, c_i_rmmov, c_i_mrmov: w_alu_a = valC;
            c_i_call, c_i_push:             w_alu_a = c_neg8;
            c_i_ret, c_i_pop:               w_alu_a = c_pos8;
            default:                        w_alu_a = '0;
        endcase
        case (icode)
            c_i_rmmov, c_i_mrmov, c_i_opq, c_i_call,
            c_i_ret, c_i_push, c_i_pop:     w_alu_b = valB;
            default:                        w_alu_b = '0;
        endcase
    end

    // OF uses the operand MSBs; sub computes aluB - aluA
    always_comb begin
        w_val_e = w_alu_a + w_alu_b;
        w_of    = (w_alu_a[WIDTH-1] == w_alu_b[WIDTH-1]) &&
                  (w_val_e[WIDTH-1] != w_alu_a[WIDTH-1]);
        if (icode == c_i_opq) begin
            case (ifun)
                4'd1: begin
                    w_val_e = w_alu_b - w_alu_a;
                    w_of    = (w_alu_a[WIDTH-1] != w_alu_b[WIDTH-1]) &&
                              (w_val_e[WIDTH-1] != w_alu_b[WIDTH-1]);
                end
                4'd2: begin
                    w_val_e = w_alu_a & w_alu_b;
                    w_of    = 1'b0;
                end
                4'd3: begin
                    w_val_e = w_alu_a ^ w_alu_b;
                    w_of    = 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_stat = c_stat_aok;
        if (icode == c_i_halt)
            w_stat = c_stat_hlt;
        else if (icode > c_i_pop)
            w_stat = c_stat_ins;
        else if ((icode == c_i_opq) && (ifun > 4'd3))
            w_stat = c_stat_ins;
        else if (((icode == c_i_rrmov) || (icode == c_i_jxx)) && (ifun > 4'd6))
            w_stat = c_stat_ins;
    end

    assign w_cc_update = w_accept && (icode == c_i_opq) && (ifun <= 4'd3);

    // Cnd reads the CC value held before this edge's update
    assign w_zf = r_cc[2];
    assign w_sf = r_cc[1];
    assign w_lt = r_cc[1] ^ r_cc[0];

    always_comb begin
        w_cnd = 1'b0;
        if ((icode == c_i_rrmov) || (icode == c_i_jxx)) begin
            case (ifun)
                4'd0:    w_cnd = 1'b1;
                4'd1:    w_cnd = w_lt | w_zf;
                4'd2:    w_cnd = w_lt;
                4'd3:    w_cnd = w_zf;
                4'd4:    w_cnd = !w_zf;
                4'd5:    w_cnd = !w_lt;
                4'd6:    w_cnd = !w_lt && !w_zf;
                default: w_cnd = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_halted    <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_icode <= '0;
            r_out_valE  <= '0;
            r_out_valA  <= '0;
            r_out_cnd   <= 1'b0;
            r_out_stat  <= c_stat_aok;
            r_cc        <= c_cc_reset;
        end else begin
            if (w_accept) begin
                r_out_valid <= 1'b1;
                r_out_icode <= icode;
                r_out_valE  <= w_val_e;
                r_out_valA  <= valA;
                r_out_cnd   <= w_cnd;
                r_out_stat  <= w_stat;
                if (w_stat != c_stat_aok)
                    r_halted <= 1'b1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (w_cc_update)
                r_cc <= {(w_val_e == '0), w_val_e[WIDTH-1], w_of};
        end
    end

`ifdef EXEC_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (rst)
            r_stall_cnt <= '0;
        else if (r_out_valid && !out_ready && (r_stall_cnt != 32'hFFFF_FFFF))
            r_stall_cnt <= r_stall_cnt + 32'd1;
    end

    assign stall_cnt = r_stall_cnt;
`endif

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_icode = r_out_icode;
    assign out_valE  = r_out_valE;
    assign out_valA  = r_out_valA;
    assign out_cnd   = r_out_cnd;
    assign out_stat  = r_out_stat;
    assign cc        = r_cc;

endmodule
`default_nettype wire

// File: tb/tb_execute_cc_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_execute_cc_stage
// Description : Directed self-checking bench for execute_cc_stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_execute_cc_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [63:0] valA;
    logic [63:0] valB;
    logic [63:0] valC;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_icode;
    logic [63:0] out_valE;
    logic [63:0] out_valA;
    logic        out_cnd;
    logic [1:0]  out_stat;
    logic [2:0]  cc;
`ifdef EXEC_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    execute_cc_stage #(.WIDTH(64)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .icode     (icode),
        .ifun      (ifun),
        .valA      (valA),
        .valB      (valB),
        .valC      (valC),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_icode (out_icode),
        .out_valE  (out_valE),
        .out_valA  (out_valA),
        .out_cnd   (out_cnd),
        .out_stat  (out_stat),
        .cc        (cc)
`ifdef EXEC_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    endtask

    // One accepted transfer: present for one edge, then sample 1 time unit later
    task automatic drive(input logic [3:0] ic, input logic [3:0] fn,
                         input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
        in_valid = 1'b1;
        icode    = ic;
        ifun     = fn;
        valA     = a;
        valB     = b;
        valC     = c;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        icode     = '0;
        ifun      = '0;
        valA      = '0;
        valB      = '0;
        valC      = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_cc", 64'(cc), 64'b100);
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_valE", out_valE, 64'd0);
        check("reset_stat", 64'(out_stat), 64'd0);
`ifdef EXEC_STALL_CNT_EN
        check("reset_stall_cnt", 64'(stall_cnt), 64'd0);
`endif

        // xor 1 ^ 2
        drive(4'h6, 4'h3, 64'd1, 64'd2, 64'd0);
        check("xor_valid", 64'(out_valid), 64'd1);
        check("xor_icode", 64'(out_icode), 64'h6);
        check("xor_valE", out_valE, 64'd3);
        check("xor_cc", 64'(cc), 64'b000);
        check("xor_stat", 64'(out_stat), 64'd0);
        check("xor_valA", out_valA, 64'd1);

        // sub 5-5 then je back-to-back
        drive(4'h6, 4'h1, 64'd5, 64'd5, 64'd0);
        check("sub_valE", out_valE, 64'd0);
        check("sub_cc", 64'(cc), 64'b100);
        drive(4'h7, 4'h3, 64'd0, 64'd0, 64'h40);
        check("je_cnd", 64'(out_cnd), 64'd1);
        check("je_valE", out_valE, 64'd0);

        // signed overflow on add
        drive(4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0);
        check("add_ovf_valE", out_valE, 64'hFFFF_FFFF_FFFF_FFFE);
        check("add_ovf_cc", 64'(cc), 64'b011);
        drive(4'h7, 4'h2, 64'd0, 64'd0, 64'd0);
        check("jl_cnd", 64'(out_cnd), 64'd0);
        drive(4'h7, 4'h1, 64'd0, 64'd0, 64'd0);
        check("jle_cnd", 64'(out_cnd), 64'd0);
        drive(4'h7, 4'h6, 64'd0, 64'd0, 64'd0);
        check("jg_cnd", 64'(out_cnd), 64'd1);
        drive(4'h7, 4'h4, 64'd0, 64'd0, 64'd0);
        check("jne_cnd", 64'(out_cnd), 64'd1);

        // stack pointer arithmetic; CC untouched
        drive(4'hA, 4'h0, 64'h1234, 64'h100, 64'd0);
        check("push_valE", out_valE, 64'hF8);
        check("push_cc", 64'(cc), 64'b011);
        check("push_valA", out_valA, 64'h1234);
        drive(4'hB, 4'h0, 64'd0, 64'h100, 64'd0);
        check("pop_valE", out_valE, 64'h108);
        drive(4'h5, 4'h0, 64'd0, 64'h20, 64'h10);
        check("mrmov_valE", out_valE, 64'h30);
        drive(4'h2, 4'h2, 64'h9, 64'd0, 64'd0);
        check("cmovl_cnd", 64'(out_cnd), 64'd0);
        check("cmovl_valE", out_valE, 64'h9);

        // stall for 3 cycles with a new instruction waiting
        drive(4'h3, 4'h0, 64'd0, 64'd0, 64'h55);
        check("irmov_valE", out_valE, 64'h55);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        icode     = 4'h2;
        ifun      = 4'h0;
        valA      = 64'h77;
        #1;
        check("stall_in_ready", 64'(in_ready), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        check("stall_valid", 64'(out_valid), 64'd1);
        check("stall_icode", 64'(out_icode), 64'h3);
        check("stall_valE", out_valE, 64'h55);
`ifdef EXEC_STALL_CNT_EN
        check("stall_cnt", 64'(stall_cnt), 64'd3);
`endif
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("after_stall_icode", 64'(out_icode), 64'h2);
        check("after_stall_valE", out_valE, 64'h77);
        check("after_stall_cnd", 64'(out_cnd), 64'd1);

        // halt locks the input, entry still drains
        drive(4'h0, 4'h0, 64'd0, 64'd0, 64'd0);
        check("hlt_stat", 64'(out_stat), 64'd1);
        check("hlt_valid", 64'(out_valid), 64'd1);
        check("hlt_in_ready", 64'(in_ready), 64'd0);
        drive(4'hC, 4'h0, 64'd0, 64'd0, 64'd0);
        check("after_hlt_valid", 64'(out_valid), 64'd0);
        check("after_hlt_icode", 64'(out_icode), 64'h0);
        check("after_hlt_in_ready", 64'(in_ready), 64'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_hlt_valid", 64'(out_valid), 64'd0);
        check("rst_hlt_cc", 64'(cc), 64'b100);
        check("rst_hlt_in_ready", 64'(in_ready), 64'd1);
        rst = 1'b0;

        // invalid OPq function: INS, CC unchanged, halts
        drive(4'h6, 4'h4, 64'd3, 64'd0, 64'd0);
        check("ins_stat", 64'(out_stat), 64'd2);
        check("ins_cc", 64'(cc), 64'b100);
        check("ins_in_ready", 64'(in_ready), 64'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // reset during a stall discards the pending result
        drive(4'h6, 4'h1, 64'd1, 64'd0, 64'd0);
        check("neg_valE", out_valE, 64'hFFFF_FFFF_FFFF_FFFF);
        check("neg_cc", 64'(cc), 64'b010);
        out_ready = 1'b0;
        rst       = 1'b1;
        @(posedge clk);
        #1;
        check("rst_stall_valid", 64'(out_valid), 64'd0);
        check("rst_stall_cc", 64'(cc), 64'b100);
        check("rst_stall_valE", out_valE, 64'd0);
        rst       = 1'b0;
        out_ready = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
